// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU load/store unit with fault detection and sub-word read-modify-write stores
module load_store_unit #(
    parameter logic [31:0] ADDR_LIMIT = 32'h00001000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        err,
    output logic        err_sticky,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] merge_addr;
    logic [31:0] merge_data;
    logic        misalign;
    logic        fault;
    logic        start_rmw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Alignment, illegal size and out-of-range checks for the presented request
    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = req_addr[0];
            2'b10:   misalign = |req_addr[1:0];
            default: misalign = 1'b1;
        endcase
        fault = req_valid && (misalign || (req_addr >= ADDR_LIMIT));
    end

    // Little-endian lane extraction with sign/zero extension, and lane merge for stores
    always_comb begin
        byte_sel = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
        half_sel = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (req_size)
            2'b00:   load_val = {{24{~req_unsigned & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{~req_unsigned & half_sel[15]}}, half_sel};
            default: load_val = mem_rdata;
        endcase
        merged = mem_rdata;
        if (req_size == 2'b00) begin
            merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        end else begin
            merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
        end
    end

    // Next-state and strobe decode; while reset is low every strobe is forced quiet
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        rdata      = 32'h0;
        err        = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = {req_addr[31:2], 2'b00};
        mem_wdata  = 32'h0;
        start_rmw  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (fault) begin
                        err = 1'b1;
                    end else if (!req_write) begin
                        mem_read = 1'b1;
                        rdata    = load_val;
                    end else if (req_size == 2'b10) begin
                        mem_write = 1'b1;
                        mem_wdata = req_wdata;
                    end else begin
                        mem_read   = 1'b1;
                        stall      = 1'b1;
                        start_rmw  = 1'b1;
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                // The held store is ignored here; only the captured merge is written
                mem_addr   = merge_addr;
                mem_write  = 1'b1;
                mem_wdata  = merge_data;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (!reset) begin
            stall      = 1'b0;
            rdata      = 32'h0;
            err        = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            start_rmw  = 1'b0;
            state_next = IDLE;
        end
    end

    // State register, merge capture for sub-word stores, and latched fault flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            merge_addr <= 32'h0;
            merge_data <= 32'h0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_next;
            if (start_rmw) begin
                merge_addr <= {req_addr[31:2], 2'b00};
                merge_data <= merged;
            end
            if (err) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_LIMIT, default 32'h00001000, meaning the first byte address outside data memory (1024 words).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1, meaning the CPU issues a memory access this cycle.
REQ-005 The block SHALL have port req_write, input, 1, meaning 1 = store and 0 = load.
REQ-006 The block SHALL have port req_size, input, 2, meaning 00 = byte, 01 = halfword, 10 = word; 11 is illegal.
REQ-007 The block SHALL have port req_unsigned, input, 1, meaning zero-extend a sub-word load (1) or sign-extend it (0).
REQ-008 The block SHALL have port req_addr, input, 32, the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32, the store data, right-aligned.
REQ-010 The block SHALL have port stall, output, 1, meaning the CPU must hold the PC and the request.
REQ-011 The block SHALL have port rdata, output, 32, the aligned and extended load result.
REQ-012 The block SHALL have port err, output, 1, a one-cycle pulse flagging a faulting access.
REQ-013 The block SHALL have port err_sticky, output, 1, latched fault status.
REQ-014 The block SHALL have ports mem_read and mem_write, outputs, 1 each, the data-memory strobes.
REQ-015 The block SHALL have ports mem_addr and mem_wdata, outputs, 32 each: word address (bits [1:0] = 0) and write word.
REQ-016 The block SHALL have port mem_rdata, input, 32, the combinational read word from data memory.

Function
REQ-017 Faults SHALL be: halfword with addr[0]=1; word with addr[1:0]!=0; req_size=11; addr >= ADDR_LIMIT.
REQ-018 A faulting request SHALL raise err for the request cycle, set err_sticky, assert no mem strobe, drive rdata=0 and stall=0.
REQ-019 mem_addr SHALL equal {req_addr[31:2],2'b00} in IDLE and the captured word address in WRITE.
REQ-020 Loads SHALL complete combinationally in one cycle with mem_read=1 and stall=0.
REQ-021 Byte-lane selection for loads SHALL be little-endian, using addr[1:0] for bytes and addr[1] for halfwords.
REQ-022 Sub-word load results SHALL be extended per req_unsigned; word loads SHALL pass mem_rdata unchanged.
REQ-023 Word stores SHALL complete in one cycle: mem_write=1, mem_wdata=req_wdata, stall=0.
REQ-024 Sub-word stores SHALL use a read-modify-write sequence over the FSM states IDLE and WRITE.
REQ-025 RMW cycle 1 (IDLE): mem_read=1, stall=1; on the clock edge the block SHALL capture the word address and mem_rdata merged with the low byte/halfword of req_wdata into the target lane, then move to WRITE.
REQ-026 RMW cycle 2 (WRITE): mem_write=1, mem_wdata=merged word, mem_read=0, stall=0; the next edge SHALL return the FSM to IDLE.
REQ-027 The request presented in WRITE is the same held store; the block SHALL ignore it and SHALL NOT restart an RMW for it.
REQ-028 With req_valid=0 in IDLE, all strobes SHALL be 0, stall=0, and rdata=0.
REQ-029 Sub-word store latency SHALL be exactly 2 cycles; every other access SHALL take 1 cycle.
REQ-030 err_sticky SHALL clear only on reset; a fault in the same cycle as a valid access is impossible, since the faulting request is the access.

Reset
REQ-031 reset=0 SHALL asynchronously force the FSM to IDLE, clear err_sticky and the merge registers, and hold mem_write, mem_read, stall and err at 0.
REQ-032 Reset asserted during WRITE SHALL abort the RMW with no memory write; after release, the block SHALL accept a new request on the first edge.

Verification
REQ-033 mem_rdata=32'h11223344, load byte, addr 0x6, signed -> rdata=32'h00000022, 1 cycle, stall=0.
REQ-034 mem_rdata=32'h80FF0000, load half, addr 0x2, signed -> rdata=32'hFFFF80FF; with unsigned -> 32'h000080FF.
REQ-035 mem_rdata=32'hAABBCCDD, store byte 0x55 at addr 0x9 -> cycle 1: mem_read=1, stall=1, mem_addr=0x8; cycle 2: mem_write=1, mem_wdata=32'hAABB55DD, stall=0.
REQ-036 Load word at addr 0x2 -> err=1 for one cycle, err_sticky=1, no strobes; store word at addr 0x1000 -> err, no mem_write.
REQ-037 Halfword store 0x1234 at addr 0x0 with reset pulsed low during WRITE -> mem_write never asserted, FSM in IDLE, err_sticky=0.
REQ-038 Back-to-back: word store at 0x10, then byte load at 0x10 -> store completes in cycle 1; load returns the new byte in cycle 2 with no stall.
